// File: rtl/note_pkg.sv
// rtl/note_pkg.sv - shared constants, state encoding and saturating add for the note sequencer
package note_pkg;

    localparam int SONG_LEN = 100;
    localparam int BEAT_W   = 7;
    localparam int CNT_W    = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_PLAY = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam logic [4:0] SONG_TAKE_ON_ME = 5'b00011;
    localparam logic [4:0] SONG_TTFAF      = 5'b11111;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/beat_divider.sv
// rtl/beat_divider.sv - mod-N clock divider producing a one-cycle tick on the wrap cycle
module beat_divider #(
    parameter int TICKS_PER_BEAT = 12_500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(TICKS_PER_BEAT);

    logic [CW-1:0] count_q, count_d;

    assign tick = en && (count_q == CW'(TICKS_PER_BEAT - 1));

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (tick) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - plays one chart per round, judges key hits and exposes an upcoming-note window
module note_sequencer
    import note_pkg::*;
#(
    parameter int TICKS_PER_BEAT = 12_500_000,
    parameter int WINDOW         = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                pause,
    input  logic [4:0]          song_select,
    input  logic                key_red,
    input  logic                key_blue,
    input  logic                key_yellow,
    input  logic [SONG_LEN-1:0] lane_red,
    input  logic [SONG_LEN-1:0] lane_blue,
    input  logic [SONG_LEN-1:0] lane_yellow,
    input  logic [CNT_W-1:0]    total_notes,
    output logic [4:0]          song_id,
    output logic [WINDOW-1:0]   win_red,
    output logic [WINDOW-1:0]   win_blue,
    output logic [WINDOW-1:0]   win_yellow,
    output logic [BEAT_W-1:0]   beat_idx,
    output logic [CNT_W-1:0]    hit_count,
    output logic [CNT_W-1:0]    miss_count,
    output logic [CNT_W-1:0]    combo,
    output logic                playing,
    output logic                done
);

    state_e                     state_q, state_d;
    logic [4:0]                 song_id_q, song_id_d;
    logic [2:0][SONG_LEN-1:0]   sr_q, sr_d;
    logic [BEAT_W-1:0]          beat_q, beat_d;
    logic [CNT_W-1:0]           hit_q, hit_d, miss_q, miss_d, combo_q, combo_d;

    logic                       div_clear, div_en, tick;
    logic [2:0]                 keys;
    logic [1:0]                 hits, misses;
    logic [SONG_LEN-1:0]        lane_v;

    assign keys   = {key_yellow, key_blue, key_red};
    assign div_en = (state_q == S_PLAY) && !pause;

    beat_divider #(.TICKS_PER_BEAT(TICKS_PER_BEAT)) u_div (
        .clk   (clk),
        .reset (reset),
        .clear (div_clear),
        .en    (div_en),
        .tick  (tick)
    );

    always_comb begin
        state_d   = state_q;
        song_id_d = song_id_q;
        sr_d      = sr_q;
        beat_d    = beat_q;
        hit_d     = hit_q;
        miss_d    = miss_q;
        combo_d   = combo_q;
        div_clear = 1'b0;
        hits      = 2'd0;
        misses    = 2'd0;
        lane_v    = '0;
        if (start) begin
            state_d   = S_LOAD;
            song_id_d = song_select;
            beat_d    = '0;
            hit_d     = '0;
            miss_d    = '0;
            combo_d   = '0;
            div_clear = 1'b1;
        end else begin
            case (state_q)
                S_LOAD: begin
                    sr_d      = {lane_yellow, lane_blue, lane_red};
                    div_clear = 1'b1;
                    state_d   = (total_notes == '0) ? S_DONE : S_PLAY;
                end
                S_PLAY: begin
                    if (!pause) begin
                        // Key is judged against the outgoing beat before that beat's misses are counted.
                        for (int l = 0; l < 3; l++) begin
                            lane_v = sr_q[l];
                            if (keys[l] && lane_v[SONG_LEN-1]) begin
                                hits                = hits + 2'd1;
                                lane_v[SONG_LEN-1] = 1'b0;
                            end
                            if (tick) begin
                                if (lane_v[SONG_LEN-1]) begin
                                    misses = misses + 2'd1;
                                end
                                lane_v = lane_v << 1;
                            end
                            sr_d[l] = lane_v;
                        end
                        if (tick) begin
                            if (beat_q == BEAT_W'(SONG_LEN - 1)) begin
                                state_d = S_DONE;
                            end else begin
                                beat_d = beat_q + 1'b1;
                            end
                        end
                        hit_d   = sat_add(hit_q, hits);
                        miss_d  = sat_add(miss_q, misses);
                        combo_d = (misses != 2'd0) ? '0 : sat_add(combo_q, hits);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            song_id_q <= '0;
            sr_q      <= '0;
            beat_q    <= '0;
            hit_q     <= '0;
            miss_q    <= '0;
            combo_q   <= '0;
        end else begin
            state_q   <= state_d;
            song_id_q <= song_id_d;
            sr_q      <= sr_d;
            beat_q    <= beat_d;
            hit_q     <= hit_d;
            miss_q    <= miss_d;
            combo_q   <= combo_d;
        end
    end

    assign song_id    = song_id_q;
    assign win_red    = sr_q[0][SONG_LEN-1 -: WINDOW];
    assign win_blue   = sr_q[1][SONG_LEN-1 -: WINDOW];
    assign win_yellow = sr_q[2][SONG_LEN-1 -: WINDOW];
    assign beat_idx   = beat_q;
    assign hit_count  = hit_q;
    assign miss_count = miss_q;
    assign combo      = combo_q;
    assign playing    = (state_q == S_PLAY);
    assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - self-checking bench for note_sequencer with a stand-in chart loader
module tb_note_sequencer;

    localparam int TPB = 4;
    localparam int WIN = 16;
    localparam int M_IDLE = 0, M_LOAD = 1, M_PLAY = 2, M_DONE = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0, pause = 1'b0;
    logic [4:0]   sel = '0;
    logic         key_r = 1'b0, key_b = 1'b0, key_y = 1'b0;
    logic [99:0]  lane_r, lane_b, lane_y;
    logic [7:0]   tot;
    logic [4:0]   song_id;
    logic [WIN-1:0] win_r, win_b, win_y;
    logic [6:0]   beat_idx;
    logic [7:0]   hit_count, miss_count, combo;
    logic         playing, done;

    logic [99:0]  ch [32][3];
    logic [7:0]   ch_tot [32];

    int n_cmp = 0;
    int n_bad = 0;

    int m_mode, m_beat, m_div, m_hit, m_miss, m_combo, m_song;
    bit m_pend [3][100];

    assign lane_r = ch[song_id][0];
    assign lane_b = ch[song_id][1];
    assign lane_y = ch[song_id][2];
    assign tot    = ch_tot[song_id];

    note_sequencer #(.TICKS_PER_BEAT(TPB), .WINDOW(WIN)) dut (
        .clk(clk), .reset(rst), .start(start), .pause(pause), .song_select(sel),
        .key_red(key_r), .key_blue(key_b), .key_yellow(key_y),
        .lane_red(lane_r), .lane_blue(lane_b), .lane_yellow(lane_y), .total_notes(tot),
        .song_id(song_id), .win_red(win_r), .win_blue(win_b), .win_yellow(win_y),
        .beat_idx(beat_idx), .hit_count(hit_count), .miss_count(miss_count), .combo(combo),
        .playing(playing), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    // Chart beat b is lane bit 99-b (beat 0 is the MSB).
    function automatic void set_note(input int s, input int l, input int b);
        ch[s][l][99-b] = 1'b1;
    endfunction

    task automatic build_charts();
        for (int s = 0; s < 32; s++) begin
            for (int l = 0; l < 3; l++) ch[s][l] = '0;
            if (s == 3) begin
                for (int b = 10; b < 30; b++) set_note(s, 2, b);
                for (int b = 11; b < 31; b++) set_note(s, 1, b);
                set_note(s, 0, 50);
                set_note(s, 0, 51);
            end else if (s == 31) begin
                for (int b = 0; b < 30; b++) set_note(s, 0, b);
                for (int b = 30; b < 60; b++) set_note(s, 1, b);
                for (int b = 60; b < 90; b++) set_note(s, 2, b);
            end else if (s == 7) begin
                for (int l = 0; l < 3; l++) ch[s][l] = '1;
            end else if (s != 0) begin
                for (int l = 0; l < 3; l++)
                    for (int b = 0; b < 100; b++)
                        if ($urandom_range(0, 3) == 0) set_note(s, l, b);
            end
            ch_tot[s] = 8'(sat($countones(ch[s][0]) + $countones(ch[s][1]) + $countones(ch[s][2])));
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_beat = 0; m_div = 0; m_hit = 0; m_miss = 0; m_combo = 0; m_song = 0;
        for (int l = 0; l < 3; l++) for (int b = 0; b < 100; b++) m_pend[l][b] = 1'b0;
    endtask

    // One clock of behaviour, driven by the inputs that the DUT will sample at the next edge.
    task automatic model_update();
        int h, m;
        bit k [3];
        k[0] = key_r; k[1] = key_b; k[2] = key_y;
        if (start) begin
            m_mode = M_LOAD; m_beat = 0; m_div = 0; m_hit = 0; m_miss = 0; m_combo = 0; m_song = int'(sel);
        end else if (m_mode == M_LOAD) begin
            for (int l = 0; l < 3; l++) for (int b = 0; b < 100; b++) m_pend[l][b] = ch[m_song][l][99-b];
            m_div = 0;
            m_mode = (ch_tot[m_song] == 0) ? M_DONE : M_PLAY;
        end else if (m_mode == M_PLAY && !pause) begin
            h = 0; m = 0;
            for (int l = 0; l < 3; l++)
                if (k[l] && m_pend[l][m_beat]) begin h++; m_pend[l][m_beat] = 1'b0; end
            if (m_div == TPB - 1) begin
                m_div = 0;
                for (int l = 0; l < 3; l++)
                    if (m_pend[l][m_beat]) begin m++; m_pend[l][m_beat] = 1'b0; end
                if (m_beat == 99) m_mode = M_DONE;
                else m_beat++;
            end else begin
                m_div++;
            end
            m_hit = sat(m_hit + h);
            m_miss = sat(m_miss + m);
            m_combo = (m > 0) ? 0 : sat(m_combo + h);
        end
    endtask

    function automatic int exp_win(input int l);
        int w;
        w = 0;
        if (m_mode == M_PLAY)
            for (int k = 0; k < WIN; k++)
                if (m_beat + k < 100 && m_pend[l][m_beat + k]) w |= (1 << (WIN - 1 - k));
        return w;
    endfunction

    task automatic compare_all();
        chk("song_id", int'(song_id), m_song);
        chk("beat_idx", int'(beat_idx), m_beat);
        chk("hit_count", int'(hit_count), m_hit);
        chk("miss_count", int'(miss_count), m_miss);
        chk("combo", int'(combo), m_combo);
        chk("playing", int'(playing), int'(m_mode == M_PLAY));
        chk("done", int'(done), int'(m_mode == M_DONE));
        if (m_mode != M_LOAD) begin
            chk("win_red", int'(win_r), exp_win(0));
            chk("win_blue", int'(win_b), exp_win(1));
            chk("win_yellow", int'(win_y), exp_win(2));
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        compare_all();
        start = 1'b0; key_r = 1'b0; key_b = 1'b0; key_y = 1'b0;
    endtask

    task automatic start_song(input int s);
        sel = 5'(s);
        start = 1'b1;
        step();
    endtask

    task automatic wait_beat(input int b);
        int n;
        n = 0;
        while ((m_beat != b || m_mode != M_PLAY) && n < 1000) begin step(); n++; end
        chk("wait_beat_timeout", n < 1000 ? 1 : 0, 1);
    endtask

    task automatic press_pending();
        if (m_mode == M_PLAY && !pause) begin
            key_r = m_pend[0][m_beat];
            key_b = m_pend[1][m_beat];
            key_y = m_pend[2][m_beat];
        end
    endtask

    typedef struct {
        int song;
        bit play_all;
        int e_hit;
        int e_miss;
        int e_combo;
    } row_t;

    row_t rows [7];

    initial begin
        int n;
        rows[0] = '{0,  1'b0, 0,   0,   0};
        rows[1] = '{3,  1'b0, 0,   42,  0};
        rows[2] = '{31, 1'b1, 90,  0,   90};
        rows[3] = '{31, 1'b0, 0,   90,  0};
        rows[4] = '{3,  1'b1, 42,  0,   42};
        rows[5] = '{7,  1'b1, 255, 0,   255};
        rows[6] = '{7,  1'b0, 0,   255, 0};

        build_charts();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;
        step();

        // Song with no notes: LOAD one cycle, then DONE.
        start_song(0);
        chk("load_playing", int'(playing), 0);
        chk("load_done", int'(done), 0);
        step();
        chk("empty_done", int'(done), 1);
        chk("empty_hits", int'(hit_count), 0);

        for (int i = 0; i < 7; i++) begin
            start_song(rows[i].song);
            n = 0;
            while (m_mode != M_DONE && n < 2000) begin
                if (rows[i].play_all) press_pending();
                step();
                n++;
            end
            chk($sformatf("row%0d_done", i), int'(done), 1);
            chk($sformatf("row%0d_hit", i), int'(hit_count), rows[i].e_hit);
            chk($sformatf("row%0d_miss", i), int'(miss_count), rows[i].e_miss);
            chk($sformatf("row%0d_combo", i), int'(combo), rows[i].e_combo);
            if (rows[i].song != 0) chk($sformatf("row%0d_cycles", i), n, 2 + 100 * TPB - 1);
        end

        // Take_on_Me: first two notes of yellow, repeated press, press on a clear lane.
        start_song(3);
        wait_beat(10);
        key_y = 1'b1; step();
        chk("tom_hit_b10", int'(hit_count), 1);
        wait_beat(11);
        key_y = 1'b1; step();
        key_y = 1'b1; step();
        key_r = 1'b1; step();
        chk("tom_hit_b11", int'(hit_count), 2);
        chk("tom_combo_b11", int'(combo), 2);
        chk("tom_miss_b11", int'(miss_count), 0);
        wait_beat(12);
        chk("tom_miss_b12", int'(miss_count), 1);
        chk("tom_combo_b12", int'(combo), 0);

        // Key on the tick cycle, then pause mid-beat.
        start_song(31);
        n = 0;
        while (!(m_mode == M_PLAY && m_beat == 0 && m_div == TPB - 1) && n < 20) begin step(); n++; end
        key_r = 1'b1; step();
        chk("tick_key_hit", int'(hit_count), 1);
        chk("tick_key_miss", int'(miss_count), 0);
        chk("tick_key_beat", int'(beat_idx), 1);
        step(); step();
        pause = 1'b1;
        key_r = 1'b1;
        repeat (10) step();
        chk("pause_beat", int'(beat_idx), 1);
        chk("pause_hit", int'(hit_count), 1);
        pause = 1'b0;
        n = 0;
        while (beat_idx == 7'd1 && n < 20) begin step(); n++; end
        chk("pause_resume_cycles", n, 2);

        // Asynchronous reset in the middle of play.
        wait_beat(5);
        step();
        rst = 1'b1;
        #2;
        model_reset();
        compare_all();
        chk("rst_playing", int'(playing), 0);
        @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;
        step();

        // Randomised traffic with restarts and pauses.
        for (int c = 0; c < 8000; c++) begin
            if ($urandom_range(0, 299) == 0 || (m_mode != M_PLAY && m_mode != M_LOAD && $urandom_range(0, 9) == 0)) begin
                sel = 5'($urandom_range(0, 31));
                start = 1'b1;
            end
            if ($urandom_range(0, 19) == 0) pause = ~pause;
            key_r = ($urandom_range(0, 2) == 0);
            key_b = ($urandom_range(0, 2) == 0);
            key_y = ($urandom_range(0, 2) == 0);
            step();
        end
        pause = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
